// File: rtl/info_browser_pkg.sv
// Shared region encoding and per-region address limits for the inspection browser.
package info_browser_pkg;

    typedef enum logic [1:0] {
        REGION_INSTRUCTION = 2'd0,
        REGION_REGISTERS   = 2'd1,
        REGION_MEMORY      = 2'd2
    } region_t;

    localparam logic [9:0] LIMIT_INSTRUCTION = 10'd255;
    localparam logic [9:0] LIMIT_REGISTERS   = 10'd31;
    localparam logic [9:0] LIMIT_MEMORY      = 10'd1023;

    function automatic logic [9:0] region_limit(input region_t r);
        case (r)
            REGION_INSTRUCTION: region_limit = LIMIT_INSTRUCTION;
            REGION_REGISTERS:   region_limit = LIMIT_REGISTERS;
            REGION_MEMORY:      region_limit = LIMIT_MEMORY;
            default:            region_limit = LIMIT_INSTRUCTION;
        endcase
    endfunction

    // Region 3 is never reachable; anything unexpected falls back to instructions.
    function automatic region_t next_region(input region_t r);
        case (r)
            REGION_INSTRUCTION: next_region = REGION_REGISTERS;
            REGION_REGISTERS:   next_region = REGION_MEMORY;
            default:            next_region = REGION_INSTRUCTION;
        endcase
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser plus level debouncer for one active-low push-button.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic resetN,
    input  logic rawN,
    output logic pressed,
    output logic pressPulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            sync_p0    <= 1'b1;
            sync_p1    <= 1'b1;
            pressed    <= 1'b0;
            pressPulse <= 1'b0;
            count      <= '0;
        end else begin
            sync_p0    <= rawN;
            sync_p1    <= sync_p0;
            pressPulse <= 1'b0;
            // A disagreeing run of DEBOUNCE_CYCLES cycles flips the stable level.
            if (!sync_p1 == pressed) begin
                count <= '0;
            end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
                pressed    <= ~pressed;
                pressPulse <= ~pressed;
                count      <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/info_browser.sv
// Turns debounced buttons into region select and in-region address with auto-repeat.
module info_browser
    import info_browser_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       keyUp,
    input  logic       keyDown,
    input  logic       keyMode,
    input  logic       keyLoad,
    input  logic [9:0] jumpAddress,
    output logic [1:0] select,
    output logic [9:0] derreference,
    output logic       updated
);

    localparam int RW = $clog2(REPEAT_DELAY + 1);

    logic up_pressed, up_pulse;
    logic dn_pressed, dn_pulse;
    logic mode_pressed, mode_pulse;
    logic load_pressed, load_pulse;
    logic unused_levels;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clock(clock), .resetN(resetN), .rawN(keyUp),
        .pressed(up_pressed), .pressPulse(up_pulse)
    );
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clock(clock), .resetN(resetN), .rawN(keyDown),
        .pressed(dn_pressed), .pressPulse(dn_pulse)
    );
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clock(clock), .resetN(resetN), .rawN(keyMode),
        .pressed(mode_pressed), .pressPulse(mode_pulse)
    );
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
        .clock(clock), .resetN(resetN), .rawN(keyLoad),
        .pressed(load_pressed), .pressPulse(load_pulse)
    );

    assign unused_levels = mode_pressed ^ load_pressed;

    logic [RW-1:0] up_held, dn_held;
    logic          up_rep, dn_rep;

    // Held count is 0 in the press-pulse cycle; after the first repeat it rewinds
    // by one period so the same compare fires every REPEAT_PERIOD cycles.
    assign up_rep = up_pressed && !up_pulse && (up_held == RW'(REPEAT_DELAY));
    assign dn_rep = dn_pressed && !dn_pulse && (dn_held == RW'(REPEAT_DELAY));

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            up_held <= '0;
        end else if (up_pulse) begin
            up_held <= RW'(1);
        end else if (!up_pressed) begin
            up_held <= '0;
        end else if (up_rep) begin
            up_held <= RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
        end else begin
            up_held <= up_held + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            dn_held <= '0;
        end else if (dn_pulse) begin
            dn_held <= RW'(1);
        end else if (!dn_pressed) begin
            dn_held <= '0;
        end else if (dn_rep) begin
            dn_held <= RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
        end else begin
            dn_held <= dn_held + 1'b1;
        end
    end

    region_t    region;
    logic [9:0] limit;
    logic       up_step, dn_step;

    assign limit   = region_limit(region);
    assign up_step = up_pulse | up_rep;
    assign dn_step = dn_pulse | dn_rep;
    assign select  = region;

    // Mode beats load beats stepping; opposing steps in one cycle cancel out.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            region       <= REGION_INSTRUCTION;
            derreference <= '0;
            updated      <= 1'b0;
        end else begin
            updated <= 1'b0;
            if (mode_pulse) begin
                region       <= next_region(region);
                derreference <= '0;
                updated      <= 1'b1;
            end else if (load_pulse) begin
                derreference <= jumpAddress & limit;
                updated      <= 1'b1;
            end else if (up_step && !dn_step) begin
                derreference <= (derreference == limit) ? 10'd0 : derreference + 10'd1;
                updated      <= 1'b1;
            end else if (dn_step && !up_step) begin
                derreference <= (derreference == 10'd0) ? limit : derreference - 10'd1;
                updated      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_info_browser.sv
// Directed plus randomized bench for info_browser with an arithmetic reference model.
module tb_info_browser;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clock = 1'b0;
    logic       resetN = 1'b0;
    logic       keyUp = 1'b1;
    logic       keyDown = 1'b1;
    logic       keyMode = 1'b1;
    logic       keyLoad = 1'b1;
    logic [9:0] jumpAddress = 10'd0;
    logic [1:0] select;
    logic [9:0] derreference;
    logic       updated;

    int total = 0;
    int passed = 0;
    int upd_cnt = 0;
    int m_sel = 0;
    int m_addr = 0;

    info_browser #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clock(clock),
        .resetN(resetN),
        .keyUp(keyUp),
        .keyDown(keyDown),
        .keyMode(keyMode),
        .keyLoad(keyLoad),
        .jumpAddress(jumpAddress),
        .select(select),
        .derreference(derreference),
        .updated(updated)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (updated === 1'b1) upd_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    function automatic int lim_of(input int s);
        return (s == 0) ? 255 : (s == 1) ? 31 : 1023;
    endfunction

    // Reference behaviour: k = 0 up, 1 down, 2 mode, 3 load.
    task automatic model_apply(input int k);
        case (k)
            0: m_addr = (m_addr + 1) % (lim_of(m_sel) + 1);
            1: m_addr = (m_addr + lim_of(m_sel)) % (lim_of(m_sel) + 1);
            2: begin m_sel = (m_sel + 1) % 3; m_addr = 0; end
            default: m_addr = int'(jumpAddress) % (lim_of(m_sel) + 1);
        endcase
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            0: keyUp = v;
            1: keyDown = v;
            2: keyMode = v;
            default: keyLoad = v;
        endcase
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic tap(input int k, input string tag);
        int u0;
        u0 = upd_cnt;
        cycles(1);
        set_key(k, 1'b0);
        cycles(10);
        set_key(k, 1'b1);
        cycles(10);
        model_apply(k);
        check({tag, " select"}, select, m_sel);
        check({tag, " addr"}, derreference, m_addr);
        check({tag, " updated"}, upd_cnt - u0, 1);
    endtask

    initial begin
        int u0;
        int k;

        // Reset state
        cycles(3);
        check("reset select", select, 0);
        check("reset addr", derreference, 0);
        check("reset updated", updated, 0);
        resetN = 1'b1;
        cycles(2);

        // Single press latency
        u0 = upd_cnt;
        keyUp = 1'b0;
        cycles(6);
        check("lat c6 addr", derreference, 0);
        check("lat c6 updated", updated, 0);
        cycles(1);
        check("lat c7 addr", derreference, 1);
        check("lat c7 updated", updated, 1);
        cycles(1);
        check("lat c8 updated", updated, 0);
        cycles(2);
        keyUp = 1'b1;
        cycles(12);
        m_addr = 1;
        check("lat pulses", upd_cnt - u0, 1);
        check("lat select", select, 0);

        // Bouncing key never settles
        u0 = upd_cnt;
        for (int i = 0; i < 10; i++) begin
            keyUp = ~keyUp;
            cycles(2);
        end
        keyUp = 1'b1;
        cycles(15);
        check("bounce addr", derreference, m_addr);
        check("bounce updated", upd_cnt - u0, 0);

        // Boundary wraps
        tap(2, "to reg");
        tap(1, "reg 0 down");
        tap(0, "reg 31 up");
        tap(2, "to mem");
        tap(2, "to instr");
        tap(1, "instr 0 down");
        tap(2, "to reg2");
        tap(2, "to mem2");
        jumpAddress = 10'd1023;
        tap(3, "mem load 1023");
        tap(0, "mem 1023 up");

        // Mode clears address; mode beats up in the same cycle
        jumpAddress = 10'd500;
        tap(3, "mem load 500");
        tap(2, "mem mode wrap");
        u0 = upd_cnt;
        cycles(1);
        keyMode = 1'b0;
        keyUp = 1'b0;
        cycles(10);
        keyMode = 1'b1;
        keyUp = 1'b1;
        cycles(10);
        model_apply(2);
        check("mode+up select", select, m_sel);
        check("mode+up addr", derreference, m_addr);
        check("mode+up updated", upd_cnt - u0, 1);

        // Masked loads
        jumpAddress = 10'h3FF;
        tap(3, "reg load 3ff");
        tap(2, "to mem3");
        tap(3, "mem load 3ff");
        tap(2, "to instr3");
        tap(3, "instr load 3ff");

        // Reset during a load debounce discards it
        u0 = upd_cnt;
        keyLoad = 1'b0;
        cycles(3);
        resetN = 1'b0;
        cycles(2);
        check("rst mid select", select, 0);
        check("rst mid addr", derreference, 0);
        keyLoad = 1'b1;
        resetN = 1'b1;
        cycles(15);
        m_sel = 0;
        m_addr = 0;
        check("rst load select", select, m_sel);
        check("rst load addr", derreference, m_addr);
        check("rst load updated", upd_cnt - u0, 0);

        // Key held through reset is re-debounced and acts afterwards
        u0 = upd_cnt;
        keyMode = 1'b0;
        cycles(3);
        resetN = 1'b0;
        cycles(2);
        resetN = 1'b1;
        cycles(12);
        keyMode = 1'b1;
        cycles(12);
        model_apply(2);
        check("held rst select", select, m_sel);
        check("held rst addr", derreference, m_addr);
        check("held rst updated", upd_cnt - u0, 1);

        // Auto-repeat over a 60-cycle hold
        u0 = upd_cnt;
        keyUp = 1'b0;
        cycles(26);
        check("hold c26 addr", derreference, 1);
        cycles(1);
        check("hold c27 addr", derreference, 2);
        cycles(33);
        keyUp = 1'b1;
        cycles(15);
        m_addr = (m_addr + 6) % (lim_of(m_sel) + 1);
        check("hold final addr", derreference, m_addr);
        check("hold updates", upd_cnt - u0, 6);

        // Up and down held together cancel
        u0 = upd_cnt;
        keyUp = 1'b0;
        keyDown = 1'b0;
        cycles(40);
        keyUp = 1'b1;
        keyDown = 1'b1;
        cycles(15);
        check("both addr", derreference, m_addr);
        check("both updated", upd_cnt - u0, 0);

        // Randomized single actions
        for (int i = 0; i < 12; i++) begin
            k = int'($urandom_range(0, 3));
            jumpAddress = 10'($urandom_range(0, 1023));
            tap(k, "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/info_browser.md
# info_browser

Upstream control stage for the FPGA inspection path. It turns the board's raw push-buttons and address switches into the `select` and `derreference` pair consumed by the word-selection mux. Each button is debounced, and the block then steps, wraps or loads the viewed address inside the currently selected region: instructions, registers or data memory. It also emits a one-cycle `updated` pulse so the display stage can refresh.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles (after synchronisation) needed to accept a key level change.
- REPEAT_DELAY, 25000000: held cycles before the first auto-repeat step.
- REPEAT_PERIOD, 5000000: cycles between later auto-repeat steps.

Ports:
- clock  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- keyUp  in  1  raw button, active-low; steps address +1.
- keyDown  in  1  raw button, active-low; steps address −1.
- keyMode  in  1  raw button, active-low; cycles the region.
- keyLoad  in  1  raw button, active-low; loads `jumpAddress`.
- jumpAddress  in  10  raw switch value, sampled only on a load press.
- select  out  2  region: 0 = instruction, 1 = registers, 2 = memory; never 3.
- derreference  out  10  address within the region.
- updated  out  1  one-cycle pulse when `select` or `derreference` is written.

## Operation
- Per key: a 2-FF synchroniser, then a debouncer.
  - The stable level flips only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any agreeing cycle clears the count.
  - A press pulse fires in the cycle the stable level becomes pressed. Release produces no pulse.
- Region limit: 255 for instruction, 31 for registers, 1023 for memory.
- `derreference` always satisfies derreference ≤ limit.
- Mode press: select goes 0→1→2→0 and `derreference` goes to 0.
- Load press: derreference = jumpAddress & limit. Upper bits are masked, not saturated, so 10'h3FF becomes 31 in the register region.
- Up step: the value after limit wraps to 0.
- Down step: the value before 0 wraps to limit.
- Auto-repeat for up/down only:
  - A held counter is cleared on the press pulse and increments each cycle the stable level is pressed.
  - An extra step fires at count = REPEAT_DELAY + k·REPEAT_PERIOD, for k ≥ 0.
  - A stable release stops and clears the counter.
- Priority when events coincide in one cycle: mode > load > up/down.
  - Up and down stepping in the same cycle cancel; nothing changes and `updated` stays 0.
  - Lower-priority events in that cycle are discarded, not queued.
- `updated` asserts on every accepted action, even if the value is unchanged. Example: load of 0 while already at 0.

## Timing
- Reset values, asynchronous on resetN low:
  - outputs: select = 0, derreference = 0, updated = 0;
  - internal: all keys stable "released", synchroniser flops released (1), all counters 0.
- Latency: a raw falling edge sampled at cycle 0 gives a press pulse at cycle DEBOUNCE_CYCLES+2. `select`, `derreference` and `updated` are registered on the next edge, cycle DEBOUNCE_CYCLES+3.
- Outputs are fully registered; there is no combinational path from keys to outputs.
- Reset mid-debounce or mid-hold discards the pending action. After release of resetN, a key still held must be re-debounced from zero and does produce a press.
- jumpAddress has no synchroniser requirement beyond being sampled in the action cycle; switches are quasi-static.

## Structure
- Package `info_browser_pkg`:
  - typedef enum logic [1:0] `region_t`: REGION_INSTRUCTION = 0, REGION_REGISTERS = 1, REGION_MEMORY = 2;
  - constants LIMIT_INSTRUCTION = 10'd255, LIMIT_REGISTERS = 10'd31, LIMIT_MEMORY = 10'd1023;
  - function `region_limit(region_t)`.
- Sub-module `key_debouncer`:
  - parameter DEBOUNCE_CYCLES;
  - ports clock, resetN, rawN → pressed (stable level), pressPulse;
  - instantiated four times.
- Auto-repeat counters, priority logic and wrap arithmetic live in the top level.

## Test plan
Run with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
1. Reset, then keyUp low for 10 cycles → derreference 0→1 at cycle 7 after the edge, single `updated` pulse, select stays 0.
2. keyUp toggling every 2 cycles for 20 cycles, then released → no change, `updated` never asserts.
3. Wrap at each region boundary:
   - region 1 at 31, up → 0;
   - region 1 at 0, down → 31;
   - region 0 at 0, down → 255;
   - region 2 at 1023, up → 0.
4. Mode press at select 2 with derreference 500 → select 0, derreference 0. Mode and up pulses in the same cycle → mode only.
5. jumpAddress = 10'h3FF, load in region 1 → 31; in region 0 → 255; in region 2 → 1023. resetN low during a load debounce → outputs 0, no load afterwards.
6. keyUp held 60 cycles from 0 → exactly 6 increments (pulse plus repeats at 26, 34, 42, 50, 58), final derreference 6. Up and down held together → value unchanged.
